ucie_ctl_rx_buffer: RTL and testbench

- Receive-side flit buffer of the UCIe controller. Sits directly downstream of the RX link receiver and is controlled by the RX control FSM.
- Accepts flits only while the FSM drives i_buffer_enable. Presents flits to the protocol layer with a valid/ready handshake.
- Reports write-while-full back to the FSM as o_overflow_detected.

---
 rtl/ucie_ctl_pkg.sv | 15 +
 rtl/ucie_ctl_rx_buffer_mem.sv | 26 ++
 rtl/ucie_ctl_rx_buffer.sv | 80 ++++++++
 tb/tb_ucie_ctl_rx_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_pkg.sv
// Shared UCIe controller definitions: default flit/buffer sizing and the
// one-hot RX control FSM state encodings used by the FSM and buffer bench.
package ucie_ctl_pkg;

  localparam int UCIE_FLIT_W       = 32;
  localparam int UCIE_RX_BUF_DEPTH = 8;

  localparam int UCIE_RX_ST_W = 3;
  typedef logic [UCIE_RX_ST_W-1:0] ucie_rx_state_t;

  localparam ucie_rx_state_t UCIE_RX_ST_IDLE     = 3'b001;
  localparam ucie_rx_state_t UCIE_RX_ST_ACTIVE   = 3'b010;
  localparam ucie_rx_state_t UCIE_RX_ST_OVERFLOW = 3'b100;

endpackage

// File: rtl/ucie_ctl_rx_buffer_mem.sv
// RX flit storage: register array with one synchronous write port and one
// asynchronous (show-ahead) read port. Contents are never reset.
module ucie_ctl_rx_buffer_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ucie_ctl_rx_buffer.sv
// UCIe RX flit buffer: FIFO between the link receiver and the protocol layer,
// gated and flushed by the RX FSM enable, with a dropped-write pulse back to it.
module ucie_ctl_rx_buffer
  import ucie_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = UCIE_FLIT_W,
  parameter int DEPTH      = UCIE_RX_BUF_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_buffer_enable,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rd_ready,
  output logic                  o_overflow_detected,
  output logic [ADDR_W:0]       o_fill_level,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [ADDR_W:0]       wr_ptr;
  logic [ADDR_W:0]       rd_ptr;
  logic                  read_fire;
  logic                  wr_accept;
  logic                  overflow_nxt;
  logic [DATA_WIDTH-1:0] head_data;

  assign o_empty      = (wr_ptr == rd_ptr);
  assign o_full       = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                        (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign o_fill_level = wr_ptr - rd_ptr;

  assign o_rd_valid   = i_buffer_enable & ~o_empty;
  assign read_fire    = i_buffer_enable & o_rd_valid & i_rd_ready;
  // A read on the same edge frees the slot, so a full buffer still accepts
  assign wr_accept    = i_buffer_enable & i_wr_valid & (~o_full | read_fire);
  assign overflow_nxt = i_buffer_enable & i_wr_valid & o_full & ~read_fire;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      o_overflow_detected <= 1'b0;
    end else if (!i_buffer_enable) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      o_overflow_detected <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (read_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      o_overflow_detected <= overflow_nxt;
    end
  end

  ucie_ctl_rx_buffer_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (i_wr_data),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (head_data)
  );

  assign o_rd_data = o_rd_valid ? head_data : '0;

endmodule

// File: tb/tb_ucie_ctl_rx_buffer.sv
// Bench for ucie_ctl_rx_buffer: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_ucie_ctl_rx_buffer;
  import ucie_ctl_pkg::*;

  localparam int DW    = UCIE_FLIT_W;
  localparam int DEPTH = UCIE_RX_BUF_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          en;
  logic          wv;
  logic [DW-1:0] wd;
  logic          rdy;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          ovf;
  logic [AW:0]   fill;
  logic          empty;
  logic          full;

  ucie_ctl_rx_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_buffer_enable     (en),
    .i_wr_valid          (wv),
    .i_wr_data           (wd),
    .o_rd_valid          (rd_valid),
    .o_rd_data           (rd_data),
    .i_rd_ready          (rdy),
    .o_overflow_detected (ovf),
    .o_fill_level        (fill),
    .o_empty             (empty),
    .o_full              (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int exp_fill, input logic [31:0] exp_head,
                           input logic exp_ovf);
    logic exp_vld;
    exp_vld = en && (exp_fill != 0);
    chk({tag, ".fill"},     32'(fill),     32'(exp_fill));
    chk({tag, ".empty"},    32'(empty),    32'(exp_fill == 0));
    chk({tag, ".full"},     32'(full),     32'(exp_fill == DEPTH));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_vld));
    chk({tag, ".rd_data"},  rd_data,       exp_vld ? exp_head : 32'h0);
    chk({tag, ".ovf"},      32'(ovf),      32'(exp_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    wv = 1'b1; wd = d; rdy = 1'b0;
    tick();
    wv = 1'b0;
  endtask

  // Directed vectors: inputs held across one edge, outputs compared after it
  typedef struct {
    logic        en;
    logic        wv;
    logic [31:0] wd;
    logic        rdy;
    int          fill;
    logic [31:0] head;
    logic        ovf;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic e, input logic w, input logic [31:0] d,
                              input logic r, input int f, input logic [31:0] h,
                              input logic o);
    vec_t v;
    v.en = e; v.wv = w; v.wd = d; v.rdy = r; v.fill = f; v.head = h; v.ovf = o;
    return v;
  endfunction

  // Reference model: the buffer is a plain queue of accepted flits
  logic [31:0] mq[$];
  logic        m_ovf;

  task automatic model_check(input string tag);
    chk_state(tag, mq.size(), (mq.size() != 0) ? mq[0] : 32'h0, m_ovf);
  endtask

  task automatic model_step();
    logic have_head;
    logic take;
    if (!en) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      have_head = (mq.size() != 0);
      take      = have_head && rdy;
      m_ovf     = 1'b0;
      if (take) void'(mq.pop_front());
      if (wv) begin
        if (mq.size() < DEPTH) mq.push_back(wd);
        else m_ovf = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; wv = 1'b0; wd = '0; rdy = 1'b0;

    // Reset values before any clock edge
    #1;
    chk_state("rst0", 0, 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    en  = 1'b1;

    // Asynchronous reset in the middle of a cycle with data stored
    for (int k = 1; k <= 3; k++) push(32'(k));
    chk_state("pre_rst", 3, 32'h1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_state("async_rst", 0, 32'h0, 1'b0);
    #1;
    rst = 1'b1;
    tick();
    chk_state("post_rst", 0, 32'h0, 1'b0);

    // Fill, overflow (twice), full read+write, drain
    for (int k = 1; k <= DEPTH; k++) vt.push_back(mk(1, 1, 32'(k), 0, k, 32'h1, 0));
    vt.push_back(mk(1, 1, 32'hDEAD, 0, 8, 32'h1, 1));
    vt.push_back(mk(1, 1, 32'hDEAE, 0, 8, 32'h1, 1));
    vt.push_back(mk(1, 0, 32'h0,    0, 8, 32'h1, 0));
    vt.push_back(mk(1, 1, 32'h9,    1, 8, 32'h2, 0));
    for (int k = 2; k <= 9; k++)
      vt.push_back(mk(1, 0, 32'h0, 1, 9 - k, (k == 9) ? 32'h0 : 32'(k + 1), 0));

    foreach (vt[i]) begin
      en = vt[i].en; wv = vt[i].wv; wd = vt[i].wd; rdy = vt[i].rdy;
      tick();
      chk_state($sformatf("vec%0d", i), vt[i].fill, vt[i].head, vt[i].ovf);
    end
    wv = 1'b0; rdy = 1'b0;

    // Wrap-around at constant fill level 4
    for (int k = 0; k < 4; k++) push(32'(100 + k));
    for (int i = 0; i < 20; i++) begin
      wv = 1'b1; wd = 32'(104 + i); rdy = 1'b1;
      #1;
      chk($sformatf("wrap_head%0d", i), rd_data, 32'(100 + i));
      tick();
      chk($sformatf("wrap_fill%0d", i), 32'(fill), 32'd4);
    end
    wv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rdy = 1'b1;
      #1;
      chk($sformatf("wrap_drain%0d", i), rd_data, 32'(120 + i));
      tick();
    end
    rdy = 1'b0;
    chk("wrap_empty", 32'(empty), 32'd1);

    // Enable drop with a flit in flight, then re-enable
    for (int k = 0; k < 5; k++) push(32'h50 + 32'(k));
    chk("en_pre_fill", 32'(fill), 32'd5);
    en = 1'b0; wv = 1'b1; wd = 32'h77;
    #1;
    chk("en_drop_vld", 32'(rd_valid), 32'd0);
    chk("en_drop_data", rd_data, 32'h0);
    tick();
    chk("en_drop_ovf", 32'(ovf), 32'd0);
    chk("en_drop_empty", 32'(empty), 32'd1);
    tick();
    en = 1'b1; wv = 1'b1; wd = 32'hA5; rdy = 1'b0;
    #1;
    chk("reen_empty", 32'(empty), 32'd1);
    tick();
    wv = 1'b0;
    chk_state("reen_first", 1, 32'hA5, 1'b0);

    // Random traffic against the queue model, starting from reset
    rst = 1'b0;
    #1;
    rst = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      en  = ($urandom_range(0, 19) != 0);
      wv  = ($urandom_range(0, 9) < 7);
      wd  = $urandom;
      rdy = ((c / 250) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
      #1;
      model_check($sformatf("rnd%0d", c));
      model_step();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
